// File: rtl/riscv_prefetch_buffer.sv
// Instruction prefetch buffer: sequential fetches to a latency-tolerant imem, an in-order
// response FIFO presented to ID, and redirect handling that drops stale in-flight responses.
module riscv_prefetch_buffer #(
    parameter int MP_XLEN            = 32,
    parameter int MP_DEPTH           = 4,
    parameter int MP_MAX_OUTSTANDING = 2,
    parameter logic [MP_XLEN-1:0] MP_RESET_PC = '0
) (
    input  logic               iclk,
    input  logic               irst,
    output logic               oimem_req_valid,
    input  logic               iimem_req_ready,
    output logic [MP_XLEN-1:0] oimem_addr,
    input  logic               iimem_rsp_valid,
    input  logic [MP_XLEN-1:0] iimem_rsp_data,
    output logic               oinstr_valid,
    output logic [MP_XLEN-1:0] oinstr,
    output logic [MP_XLEN-1:0] opc,
    input  logic               iinstr_ready,
    input  logic               iredirect,
    input  logic [MP_XLEN-1:0] iredirect_pc
);

    localparam int PW = $clog2(MP_DEPTH);
    localparam int CW = $clog2(MP_DEPTH + 1);
    localparam int IW = $clog2(MP_MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(MP_DEPTH + MP_MAX_OUTSTANDING + 1);
    localparam logic [MP_XLEN-1:0] PC_STEP = MP_XLEN'(4);

    logic [MP_XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [MP_XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [IW-1:0]      inflight_q, inflight_d;
    logic [IW-1:0]      drop_q, drop_d;
    logic [MP_XLEN-1:0] fifo_pc   [MP_DEPTH];
    logic [MP_XLEN-1:0] fifo_data [MP_DEPTH];

    logic [SW-1:0]      credit_used;
    logic [MP_XLEN-1:0] redirect_pc_al;
    logic               accept;
    logic               rsp_take;
    logic               push;
    logic               pop;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^iredirect_pc[1:0];
    assign redirect_pc_al = {iredirect_pc[MP_XLEN-1:2], 2'b00};

    // Requests still owed to the current stream (drop counts the stale ones) reserve FIFO slots.
    assign credit_used = SW'(count_q) + SW'(inflight_q) - SW'(drop_q);

    assign oimem_req_valid = !irst && !iredirect
                          && (inflight_q < IW'(MP_MAX_OUTSTANDING))
                          && (credit_used < SW'(MP_DEPTH));
    assign oimem_addr   = fetch_pc_q;
    assign accept       = oimem_req_valid && iimem_req_ready;
    assign rsp_take     = iimem_rsp_valid && (inflight_q != '0);
    assign push         = rsp_take && (drop_q == '0) && !iredirect;
    assign pop          = (count_q != '0) && iinstr_ready && !iredirect;

    assign oinstr_valid = (count_q != '0);
    assign oinstr       = fifo_data[rd_ptr_q];
    assign opc          = fifo_pc[rd_ptr_q];

    always_comb begin
        inflight_d = inflight_q + IW'(accept) - IW'(rsp_take);
        drop_d     = drop_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        fetch_pc_d = accept ? fetch_pc_q + PC_STEP : fetch_pc_q;
        rsp_pc_d   = push ? rsp_pc_q + PC_STEP : rsp_pc_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        if (rsp_take && (drop_q != '0)) begin
            drop_d = drop_q - IW'(1);
        end
        if (iredirect) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            drop_d     = inflight_q - IW'(rsp_take);
            count_d    = '0;
            fetch_pc_d = redirect_pc_al;
            rsp_pc_d   = redirect_pc_al;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            fetch_pc_q <= MP_RESET_PC;
            rsp_pc_q   <= MP_RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            for (int i = 0; i < MP_DEPTH; i++) begin
                fifo_pc[i]   <= MP_RESET_PC;
                fifo_data[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            if (push) begin
                fifo_pc[wr_ptr_q]   <= rsp_pc_q;
                fifo_data[wr_ptr_q] <= iimem_rsp_data;
            end
        end
    end

endmodule
